// File: rtl/caravel_io_if.sv
// Pin-side bundle between user_project_wrapper and caravel_io_adapter.
// master = wrapper/pad side driving the raw pins, slave = the adapter.
interface caravel_io_if #(
  parameter int N_BUTTONS = 4,
  parameter int N_OUTS    = 6
);
  logic                 ext_reset_n;
  logic                 gpio_ready;
  logic [N_BUTTONS-1:0] btn_n_in;
  logic [N_BUTTONS-1:0] btn_level;
  logic [N_BUTTONS-1:0] btn_press;
  logic                 design_reset;
  logic [N_OUTS-1:0]    out_oeb;
  logic                 debug_design_reset;
  logic                 debug_gpio_ready;
  logic [1:0]           debug_oeb;

  modport master (
    output ext_reset_n, gpio_ready, btn_n_in,
    input  btn_level, btn_press, design_reset, out_oeb,
           debug_design_reset, debug_gpio_ready, debug_oeb
  );

  modport slave (
    input  ext_reset_n, gpio_ready, btn_n_in,
    output btn_level, btn_press, design_reset, out_oeb,
           debug_design_reset, debug_gpio_ready, debug_oeb
  );
endinterface

// File: rtl/caravel_io_adapter.sv
// Caravel-side adapter: synchronises/debounces buttons, builds a stretched
// design reset and keeps design pads tristated until firmware flags gpio_ready.
module caravel_io_adapter #(
  parameter int N_BUTTONS     = 4,
  parameter int N_OUTS        = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 4,
  parameter int RESET_HOLD    = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  caravel_io_if.slave  io
);

  localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]        HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX    = {DEBOUNCE_BITS{1'b1}};

  logic [SYNC_STAGES-1:0]                    ext_sync;
  logic [SYNC_STAGES-1:0]                    rdy_sync;
  logic [N_BUTTONS-1:0][SYNC_STAGES-1:0]     btn_sync;
  logic [N_BUTTONS-1:0][DEBOUNCE_BITS-1:0]   db_cnt;
  logic [HOLD_W-1:0]                         hold_cnt;
  logic [N_BUTTONS-1:0]                      btn_level;
  logic [N_BUTTONS-1:0]                      btn_press;
  logic                                      design_reset;
  logic [N_OUTS-1:0]                         out_oeb;

  logic                 ext_s;
  logic                 rdy_s;
  logic                 rst_req;
  logic [N_BUTTONS-1:0] btn_raw;

  assign ext_s   = ext_sync[SYNC_STAGES-1];
  assign rdy_s   = rdy_sync[SYNC_STAGES-1];
  assign rst_req = ~ext_s | ~rdy_s;

  always_comb begin
    btn_raw = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      btn_raw[i] = ~btn_sync[i][SYNC_STAGES-1];
    end
  end

  // A reset request of any length reloads the hold window; debounce keeps
  // running under design_reset so the game core sees settled levels on exit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ext_sync     <= '0;
      rdy_sync     <= '0;
      btn_sync     <= '1;
      db_cnt       <= '0;
      btn_level    <= '0;
      btn_press    <= '0;
      hold_cnt     <= HOLD_INIT;
      design_reset <= 1'b1;
      out_oeb      <= '1;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], io.ext_reset_n};
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], io.gpio_ready};

      if (rst_req) begin
        hold_cnt     <= HOLD_INIT;
        design_reset <= 1'b1;
      end else begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        design_reset <= (hold_cnt != '0);
      end

      out_oeb   <= {N_OUTS{~rdy_s}};
      btn_press <= '0;

      for (int i = 0; i < N_BUTTONS; i++) begin
        btn_sync[i] <= {btn_sync[i][SYNC_STAGES-2:0], io.btn_n_in[i]};
        if (btn_raw[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != DB_MAX) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end else begin
          db_cnt[i]    <= '0;
          btn_level[i] <= btn_raw[i];
          btn_press[i] <= btn_raw[i] & ~design_reset;
        end
      end
    end
  end

  assign io.btn_level          = btn_level;
  assign io.btn_press          = btn_press;
  assign io.design_reset       = design_reset;
  assign io.out_oeb            = out_oeb;
  assign io.debug_design_reset = design_reset;
  assign io.debug_gpio_ready   = rdy_s;
  assign io.debug_oeb          = 2'b00;

endmodule

// File: tb/tb_caravel_io_adapter.sv
// Self-checking bench for caravel_io_adapter: directed scenarios plus random
// pin activity, all checked every cycle against a pin-history reference model.
module tb_caravel_io_adapter;

  localparam int NB   = 4;
  localparam int NO   = 6;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int MAXE = 8000;

  logic clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 clk = ~clk;

  caravel_io_if #(.N_BUTTONS(NB), .N_OUTS(NO)) io ();

  caravel_io_adapter #(
    .N_BUTTONS(NB), .N_OUTS(NO), .SYNC_STAGES(SYNC),
    .DEBOUNCE_BITS(DB), .RESET_HOLD(HOLD)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(wb_rst),
    .io(io.slave)
  );

  int checks = 0;
  int errors = 0;

  // Pin values as sampled at each rising edge, indexed by edge number.
  bit          h_rst [MAXE];
  bit          h_ext [MAXE];
  bit          h_rdy [MAXE];
  logic [NB-1:0] h_btn [MAXE];
  int          edge_n = 0;

  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_press = '0;
  logic          m_dr = 1'b1;
  logic [NO-1:0] m_oeb = '1;
  logic          m_dbg_rdy = 1'b0;
  int            run_len [NB];

  // A synchronised value seen before edge e is the pin from SYNC edges
  // earlier, unless wb_rst hit any of the SYNC edges in between.
  function automatic bit in_rst_win(int e);
    for (int d = 1; d <= SYNC; d++) begin
      if (e - d < 0) return 1'b1;
      if (h_rst[e-d]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit ext_s(int e);
    return in_rst_win(e) ? 1'b0 : h_ext[e-SYNC];
  endfunction

  function automatic bit rdy_s(int e);
    return in_rst_win(e) ? 1'b0 : h_rdy[e-SYNC];
  endfunction

  function automatic logic [NB-1:0] btn_s(int e);
    return in_rst_win(e) ? {NB{1'b1}} : h_btn[e-SYNC];
  endfunction

  function automatic bit rst_event(int e);
    if (e < 0) return 1'b1;
    return h_rst[e] || !ext_s(e) || !rdy_s(e);
  endfunction

  // design_reset is high after edge k iff any reset cause was seen at an
  // edge within the last HOLD+1 edges.
  task automatic modelEdge(input int k);
    logic          prev_dr;
    logic [NB-1:0] raw;
    prev_dr = m_dr;
    m_dr = 1'b0;
    for (int e = k - HOLD; e <= k; e++) if (rst_event(e)) m_dr = 1'b1;
    m_oeb = (h_rst[k] || !rdy_s(k)) ? {NO{1'b1}} : {NO{1'b0}};
    m_dbg_rdy = rdy_s(k + 1);
    m_press = '0;
    if (h_rst[k]) begin
      m_level = '0;
      for (int i = 0; i < NB; i++) run_len[i] = 0;
    end else begin
      raw = ~btn_s(k);
      for (int i = 0; i < NB; i++) begin
        if (raw[i] != m_level[i]) begin
          run_len[i]++;
          if (run_len[i] == (1 << DB)) begin
            m_level[i] = raw[i];
            run_len[i] = 0;
            m_press[i] = raw[i] & ~prev_dr;
          end
        end else begin
          run_len[i] = 0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, actual, expected);
    end
  endtask

  // Drive pins at the falling edge, let one rising edge sample them, then
  // compare every output with the model just after the edge.
  task automatic applyStimulus(input logic rst, input logic ext, input logic rdy,
                               input logic [NB-1:0] btn_n);
    @(negedge clk);
    wb_rst = rst;
    io.ext_reset_n = ext;
    io.gpio_ready = rdy;
    io.btn_n_in = btn_n;
    @(posedge clk);
    h_rst[edge_n] = rst;
    h_ext[edge_n] = ext;
    h_rdy[edge_n] = rdy;
    h_btn[edge_n] = btn_n;
    modelEdge(edge_n);
    #1;
    checkOutput("design_reset", io.design_reset, m_dr);
    checkOutput("debug_design_reset", io.debug_design_reset, m_dr);
    checkOutput("out_oeb", io.out_oeb, m_oeb);
    checkOutput("btn_level", io.btn_level, m_level);
    checkOutput("btn_press", io.btn_press, m_press);
    checkOutput("debug_gpio_ready", io.debug_gpio_ready, m_dbg_rdy);
    checkOutput("debug_oeb", io.debug_oeb, 2'b00);
    edge_n++;
  endtask

  logic          r_ext, r_rdy;
  logic [NB-1:0] r_btn;
  int            dur [NB];
  int            ext_low;
  logic [NB-1:0] press_seen;

  initial begin
    for (int i = 0; i < NB; i++) run_len[i] = 0;
    io.ext_reset_n = 1'b0;
    io.gpio_ready = 1'b0;
    io.btn_n_in = '1;

    // Reset with random pins
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), NB'($urandom));
    checkOutput("t1_design_reset", io.design_reset, 1'b1);
    checkOutput("t1_out_oeb", io.out_oeb, 6'h3F);
    checkOutput("t1_btn_level", io.btn_level, 4'h0);
    checkOutput("t1_btn_press", io.btn_press, 4'h0);

    // Release from reset with pins ready
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      checkOutput("t2_design_reset", io.design_reset, (k <= 10) ? 1 : 0);
      checkOutput("t2_out_oeb", io.out_oeb, (k >= 3) ? 6'h00 : 6'h3F);
    end

    // Short glitch on button 0 must not register
    for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hE);
    for (int k = 1; k <= 25; k++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
    checkOutput("t3_glitch_level", io.btn_level, 4'h0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hE);
      checkOutput("t3_press_level", io.btn_level[0], (k >= 18) ? 1 : 0);
      checkOutput("t3_press_pulse", io.btn_press[0], (k == 18) ? 1 : 0);
    end
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      checkOutput("t3_release_level", io.btn_level[0], (k < 18) ? 1 : 0);
      checkOutput("t3_release_pulse", io.btn_press[0], 0);
    end

    // One-cycle external reset pulse
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
    checkOutput("t4_design_reset", io.design_reset, 0);
    for (int k = 2; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      checkOutput("t4_design_reset", io.design_reset, (k >= 3 && k <= 11) ? 1 : 0);
    end

    // gpio_ready dropping re-tristates pads and resets the core
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
      checkOutput("t5_out_oeb", io.out_oeb, (k >= 3) ? 6'h3F : 6'h00);
      checkOutput("t5_design_reset", io.design_reset, (k >= 3) ? 1 : 0);
      checkOutput("t5_debug_gpio_ready", io.debug_gpio_ready, (k >= 2) ? 0 : 1);
    end
    for (int k = 1; k <= 15; k++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);

    // All buttons pressed while the core is held in reset: no pulses
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
    press_seen = '0;
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0);
      press_seen |= io.btn_press;
    end
    checkOutput("t6_level_in_reset", io.btn_level, 4'hF);
    checkOutput("t6_no_press_in_reset", press_seen, 4'h0);
    for (int k = 1; k <= 22; k++) applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
    for (int k = 1; k <= 15; k++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h0);
      checkOutput("t6_press_all", io.btn_press, (k == 18) ? 4'hF : 4'h0);
    end
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);

    // Random pin activity
    r_ext = 1'b1;
    r_rdy = 1'b1;
    r_btn = '1;
    ext_low = 0;
    for (int i = 0; i < NB; i++) dur[i] = $urandom_range(1, 45);
    for (int c = 0; c < 3000; c++) begin
      if (ext_low > 0) begin
        ext_low--;
        r_ext = 1'b0;
      end else begin
        r_ext = 1'b1;
        if ($urandom_range(0, 149) == 0) ext_low = $urandom_range(1, 4);
      end
      if (r_rdy ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
        r_rdy = ~r_rdy;
      for (int i = 0; i < NB; i++) begin
        if (dur[i] == 0) begin
          r_btn[i] = ~r_btn[i];
          dur[i] = $urandom_range(1, 45);
        end else begin
          dur[i]--;
        end
      end
      applyStimulus(($urandom_range(0, 599) == 0), r_ext, r_rdy, r_btn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
